// File: rtl/mv_phase_sequencer.sv
// Sequences the mXv and vXv compute units through guarded iterations until convergence or an iteration limit.
// Outputs are decoded from registered state only; a finish pulse arriving in the wrong phase is dropped and flagged.
module mv_phase_sequencer #(
    parameter int STARTUP_CYC = 2,
    parameter int GAP_CYC     = 4,
    parameter int ITER_W      = 16,
    parameter int MAX_ITER    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mxv_finish,
    input  logic              vxv_finish,
    input  logic              converged,
    output logic              mxv_run,
    output logic              vxv_run,
    output logic              busy,
    output logic              halt,
    output logic [ITER_W-1:0] iter_count,
    output logic              protocol_err
);

    localparam int CNT_MAX = (STARTUP_CYC > GAP_CYC) ? STARTUP_CYC : GAP_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  START_LOAD = CNT_W'(STARTUP_CYC - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD   = CNT_W'(GAP_CYC - 1);
    localparam logic [ITER_W-1:0] ITER_LIM   = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {
        IDLE,
        STARTUP,
        MXV,
        GAP1,
        VXV,
        GAP2,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [ITER_W-1:0] iter_nxt;
    logic [ITER_W-1:0] iter_inc;
    logic              err_nxt;
    logic              conv_latch;
    logic              conv_nxt;
    logic              err_set;

    assign iter_inc = iter_count + ITER_W'(1);

    // A finish is only meaningful in its own phase; anything else is a protocol violation.
    assign err_set = (mxv_finish && (state != MXV)) || (vxv_finish && (state != VXV));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        iter_nxt  = iter_count;
        err_nxt   = protocol_err | err_set;
        conv_nxt  = conv_latch;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = STARTUP;
                    cnt_nxt   = START_LOAD;
                    iter_nxt  = '0;
                    err_nxt   = 1'b0;
                    conv_nxt  = 1'b0;
                end
            end
            STARTUP: begin
                if (cnt == '0) begin
                    state_nxt = MXV;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            MXV: begin
                if (mxv_finish) begin
                    state_nxt = GAP1;
                    cnt_nxt   = GAP_LOAD;
                end
            end
            GAP1: begin
                if (cnt == '0) begin
                    state_nxt = VXV;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            VXV: begin
                if (vxv_finish) begin
                    state_nxt = GAP2;
                    cnt_nxt   = GAP_LOAD;
                    conv_nxt  = converged;
                end
            end
            GAP2: begin
                if (cnt == '0) begin
                    iter_nxt = iter_inc;
                    // The limit compares against the post-increment count so MAX_ITER=1 stops after one pass.
                    if (conv_latch || ((MAX_ITER != 0) && (iter_inc == ITER_LIM))) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = MXV;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            iter_count   <= '0;
            protocol_err <= 1'b0;
            conv_latch   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            iter_count   <= iter_nxt;
            protocol_err <= err_nxt;
            conv_latch   <= conv_nxt;
        end
    end

    assign mxv_run = (state == MXV);
    assign vxv_run = (state == VXV);
    assign busy    = (state != IDLE) && (state != DONE);
    assign halt    = (state == DONE);

endmodule

// File: tb/tb_mv_phase_sequencer.sv
// Directed bench for mv_phase_sequencer: one unlimited instance (a_*) and one MAX_ITER=1 instance (b_*) share stimulus.
module tb_mv_phase_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        mxv_finish = 1'b0;
    logic        vxv_finish = 1'b0;
    logic        converged = 1'b0;

    logic        a_mxv_run, a_vxv_run, a_busy, a_halt, a_protocol_err;
    logic [15:0] a_iter_count;
    logic        b_mxv_run, b_vxv_run, b_busy, b_halt, b_protocol_err;
    logic [15:0] b_iter_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mv_phase_sequencer #(.STARTUP_CYC(2), .GAP_CYC(4), .ITER_W(16), .MAX_ITER(0)) dut_a (
        .clk(clk), .reset(reset), .start(start), .mxv_finish(mxv_finish),
        .vxv_finish(vxv_finish), .converged(converged), .mxv_run(a_mxv_run),
        .vxv_run(a_vxv_run), .busy(a_busy), .halt(a_halt),
        .iter_count(a_iter_count), .protocol_err(a_protocol_err)
    );

    mv_phase_sequencer #(.STARTUP_CYC(2), .GAP_CYC(4), .ITER_W(16), .MAX_ITER(1)) dut_b (
        .clk(clk), .reset(reset), .start(start), .mxv_finish(mxv_finish),
        .vxv_finish(vxv_finish), .converged(converged), .mxv_run(b_mxv_run),
        .vxv_run(b_vxv_run), .busy(b_busy), .halt(b_halt),
        .iter_count(b_iter_count), .protocol_err(b_protocol_err)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; mxv_finish = 1'b0; vxv_finish = 1'b0; converged = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_mxv_a();
        int n = 0;
        while (a_mxv_run !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        total_cnt++;
        if (a_mxv_run !== 1'b1) $display("FAIL wait_mxv_run: got %b, need 1 within 200 cycles", a_mxv_run);
        else pass_cnt++;
    endtask

    task automatic wait_vxv_a();
        int n = 0;
        while (a_vxv_run !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        total_cnt++;
        if (a_vxv_run !== 1'b1) $display("FAIL wait_vxv_run: got %b, need 1 within 200 cycles", a_vxv_run);
        else pass_cnt++;
    endtask

    task automatic pulse_mxv();
        mxv_finish = 1'b1;
        tick();
        mxv_finish = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        total_cnt++;
        if ({a_mxv_run, a_vxv_run, a_busy, a_halt, a_protocol_err} !== 5'b0 || a_iter_count !== 16'd0)
            $display("FAIL reset_a: flags %b iter %0d, need 00000 iter 0",
                     {a_mxv_run, a_vxv_run, a_busy, a_halt, a_protocol_err}, a_iter_count);
        else pass_cnt++;
        total_cnt++;
        if ({b_mxv_run, b_vxv_run, b_busy, b_halt, b_protocol_err} !== 5'b0 || b_iter_count !== 16'd0)
            $display("FAIL reset_b: flags %b iter %0d, need 00000 iter 0",
                     {b_mxv_run, b_vxv_run, b_busy, b_halt, b_protocol_err}, b_iter_count);
        else pass_cnt++;
        repeat (3) tick();
        total_cnt++;
        if ({a_mxv_run, a_busy, a_halt} !== 3'b000)
            $display("FAIL idle_hold: run/busy/halt %b, need 000", {a_mxv_run, a_busy, a_halt});
        else pass_cnt++;
    endtask

    task automatic test_single();
        do_reset();
        kick();
        total_cnt++;
        if ({b_busy, b_mxv_run} !== 2'b10)
            $display("FAIL busy_after_start: busy/mxv %b, need 10", {b_busy, b_mxv_run});
        else pass_cnt++;
        tick();
        total_cnt++;
        if (b_mxv_run !== 1'b0) $display("FAIL mxv_early: got %b, need 0", b_mxv_run);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (b_mxv_run !== 1'b1) $display("FAIL mxv_rise: got %b, need 1", b_mxv_run);
        else pass_cnt++;
        repeat (4) tick();
        pulse_mxv();
        // A start inside GAP1 must not restart the run.
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if ({b_mxv_run, b_vxv_run} !== 2'b00)
                $display("FAIL gap_low_%0d: mxv/vxv %b, need 00", i, {b_mxv_run, b_vxv_run});
            else pass_cnt++;
            if (i == 0) start = 1'b1;
            tick();
            start = 1'b0;
        end
        total_cnt++;
        if ({b_vxv_run, b_busy} !== 2'b11)
            $display("FAIL vxv_rise: vxv/busy %b, need 11", {b_vxv_run, b_busy});
        else pass_cnt++;
        repeat (2) tick();
        vxv_finish = 1'b1;
        tick();
        vxv_finish = 1'b0;
        total_cnt++;
        if (b_vxv_run !== 1'b0) $display("FAIL vxv_fall: got %b, need 0", b_vxv_run);
        else pass_cnt++;
        repeat (3) tick();
        total_cnt++;
        if (b_halt !== 1'b0 || b_iter_count !== 16'd0)
            $display("FAIL gap2_hold: halt %b iter %0d, need 0 iter 0", b_halt, b_iter_count);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({b_halt, b_busy, b_mxv_run, b_protocol_err} !== 4'b1000 || b_iter_count !== 16'd1)
            $display("FAIL single_done: halt/busy/mxv/err %b iter %0d, need 1000 iter 1",
                     {b_halt, b_busy, b_mxv_run, b_protocol_err}, b_iter_count);
        else pass_cnt++;
    endtask

    task automatic test_converge();
        do_reset();
        converged = 1'b1;
        kick();
        for (int k = 1; k <= 3; k++) begin
            wait_mxv_a();
            converged = 1'b1;
            pulse_mxv();
            converged = 1'b0;
            wait_vxv_a();
            vxv_finish = 1'b1;
            converged = (k == 3);
            tick();
            vxv_finish = 1'b0;
            converged = 1'b1;
            repeat (3) tick();
            total_cnt++;
            if (a_iter_count !== 16'(k - 1) || a_halt !== 1'b0)
                $display("FAIL conv_gap_%0d: iter %0d halt %b, need iter %0d halt 0", k, a_iter_count, a_halt, k - 1);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (k < 3) begin
                if (a_iter_count !== 16'(k) || a_mxv_run !== 1'b1)
                    $display("FAIL conv_iter_%0d: iter %0d mxv %b, need iter %0d mxv 1", k, a_iter_count, a_mxv_run, k);
                else pass_cnt++;
            end else begin
                if (a_iter_count !== 16'd3 || {a_halt, a_mxv_run, a_busy} !== 3'b100)
                    $display("FAIL conv_done: iter %0d halt/mxv/busy %b, need iter 3 100",
                             a_iter_count, {a_halt, a_mxv_run, a_busy});
                else pass_cnt++;
            end
        end
        converged = 1'b0;
        repeat (10) tick();
        total_cnt++;
        if ({a_mxv_run, a_halt} !== 2'b01 || a_iter_count !== 16'd3)
            $display("FAIL conv_stay: mxv/halt %b iter %0d, need 01 iter 3", {a_mxv_run, a_halt}, a_iter_count);
        else pass_cnt++;
    endtask

    task automatic test_protocol_err();
        do_reset();
        kick();
        wait_mxv_a();
        total_cnt++;
        if (a_protocol_err !== 1'b0) $display("FAIL err_clear: got %b, need 0", a_protocol_err);
        else pass_cnt++;
        mxv_finish = 1'b1; vxv_finish = 1'b1;
        tick();
        mxv_finish = 1'b0; vxv_finish = 1'b0;
        total_cnt++;
        if ({a_protocol_err, a_mxv_run, a_vxv_run} !== 3'b100)
            $display("FAIL both_finish: err/mxv/vxv %b, need 100", {a_protocol_err, a_mxv_run, a_vxv_run});
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (a_vxv_run !== 1'b0) $display("FAIL both_gap_%0d: vxv %b, need 0", i, a_vxv_run);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (a_vxv_run !== 1'b1) $display("FAIL both_vxv_rise: got %b, need 1", a_vxv_run);
        else pass_cnt++;

        do_reset();
        kick();
        wait_mxv_a();
        pulse_mxv();
        vxv_finish = 1'b1;
        tick();
        vxv_finish = 1'b0;
        total_cnt++;
        if ({a_protocol_err, a_vxv_run} !== 2'b10)
            $display("FAIL gap1_vxv_pulse: err/vxv %b, need 10", {a_protocol_err, a_vxv_run});
        else pass_cnt++;
        repeat (2) tick();
        total_cnt++;
        if (a_vxv_run !== 1'b0) $display("FAIL gap1_no_early: vxv %b, need 0", a_vxv_run);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({a_vxv_run, a_mxv_run} !== 2'b10)
            $display("FAIL gap1_vxv_rise: vxv/mxv %b, need 10", {a_vxv_run, a_mxv_run});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_vxv();
        do_reset();
        kick();
        wait_mxv_a();
        pulse_mxv();
        wait_vxv_a();
        vxv_finish = 1'b1;
        tick();
        vxv_finish = 1'b0;
        wait_mxv_a();
        pulse_mxv();
        wait_vxv_a();
        total_cnt++;
        if (a_iter_count !== 16'd1) $display("FAIL pre_reset_iter: got %0d, need 1", a_iter_count);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        total_cnt++;
        if ({a_mxv_run, a_vxv_run, a_busy, a_halt, a_protocol_err} !== 5'b0 || a_iter_count !== 16'd0)
            $display("FAIL mid_reset: flags %b iter %0d, need 00000 iter 0",
                     {a_mxv_run, a_vxv_run, a_busy, a_halt, a_protocol_err}, a_iter_count);
        else pass_cnt++;
        repeat (3) tick();
        total_cnt++;
        if ({a_busy, a_mxv_run} !== 2'b00)
            $display("FAIL mid_reset_idle: busy/mxv %b, need 00", {a_busy, a_mxv_run});
        else pass_cnt++;
    endtask

    task automatic test_restart();
        do_reset();
        kick();
        wait_mxv_a();
        pulse_mxv();
        pulse_mxv();
        wait_vxv_a();
        vxv_finish = 1'b1;
        tick();
        vxv_finish = 1'b0;
        repeat (4) tick();
        total_cnt++;
        if ({b_halt, b_protocol_err} !== 2'b11 || b_iter_count !== 16'd1)
            $display("FAIL pre_restart: halt/err %b iter %0d, need 11 iter 1", {b_halt, b_protocol_err}, b_iter_count);
        else pass_cnt++;
        kick();
        total_cnt++;
        if ({b_halt, b_protocol_err, b_busy, b_mxv_run} !== 4'b0010 || b_iter_count !== 16'd0)
            $display("FAIL restart: halt/err/busy/mxv %b iter %0d, need 0010 iter 0",
                     {b_halt, b_protocol_err, b_busy, b_mxv_run}, b_iter_count);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (b_mxv_run !== 1'b0) $display("FAIL restart_mxv_early: got %b, need 0", b_mxv_run);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (b_mxv_run !== 1'b1) $display("FAIL restart_mxv_rise: got %b, need 1", b_mxv_run);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_converge();
        test_protocol_err();
        test_reset_mid_vxv();
        test_restart();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached after %0d/%0d checks", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
